// File: rtl/instruction_fetch_fifo_pkg.sv
// Shared constants for the instruction fetch queue: default geometry and
// the helper that sizes the read/write pointers.
package ifq_pkg;

   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_INSNS_PER_BLOCK = 4;
   localparam int DEF_DEPTH           = 4;

   // Pointer width for a queue of the given depth; never narrower than one bit
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instruction_fetch_fifo_if.sv
// Handshake bundle between the fetch unit, the block queue and the decoder.
// The master side is the producer/consumer pair, the slave side is the queue.
interface instruction_fetch_fifo_if
   import ifq_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int INSNS_PER_BLOCK = DEF_INSNS_PER_BLOCK,
   parameter int DEPTH           = DEF_DEPTH
);

   localparam int BW = INSNS_PER_BLOCK * DATA_WIDTH;
   localparam int CW = ptr_width(DEPTH) + 1;

   logic          flush;
   logic          push_valid;
   logic          push_ready;
   logic [BW-1:0] block_in;
   logic          pop_valid;
   logic          pop_ready;
   logic [BW-1:0] block_out;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          almost_full;

   modport master (
      output flush, push_valid, block_in, pop_ready,
      input  push_ready, pop_valid, block_out, count, full, empty, almost_full
   );

   modport slave (
      input  flush, push_valid, block_in, pop_ready,
      output push_ready, pop_valid, block_out, count, full, empty, almost_full
   );

endinterface

// File: rtl/instruction_fetch_fifo_register.sv
// Generic enabled register used as one storage slot of the fetch queue.
// Clears to zero on reset and on a synchronous flush.
module Register #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Slot contents: cleared by reset or flush, otherwise loaded when enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instruction_fetch_fifo.sv
// Instruction fetch queue: buffers whole fetch blocks from the instruction ROM
// and hands them to the decoder in strict FIFO order. No bypass path, so a
// block becomes visible on block_out one edge after it is pushed.
module instruction_fetch_fifo
   import ifq_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int INSNS_PER_BLOCK = DEF_INSNS_PER_BLOCK,
   parameter int DEPTH           = DEF_DEPTH,
   parameter int AFULL_LEVEL     = DEPTH - 1
) (
   input logic                      clk,
   input logic                      reset,
   instruction_fetch_fifo_if.slave  bus
);

   localparam int BW = INSNS_PER_BLOCK * DATA_WIDTH;
   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;
   logic [DEPTH-1:0] wr_onehot;
   logic [DEPTH-1:0] wr_en;
   logic [BW-1:0]    entries [DEPTH];
   logic [BW-1:0]    rd_data;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // A full queue refuses pushes even if a pop frees a slot on the same edge;
   // flush wins over both handshakes.
   assign do_push = bus.push_valid & ~full & ~bus.flush;
   assign do_pop  = bus.pop_ready & ~empty & ~bus.flush;

   assign wr_onehot = DEPTH'(1) << wr_ptr;
   assign wr_en     = wr_onehot & {DEPTH{do_push}};

   // One slot per entry, written only when it is the push target
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      Register #(
         .WIDTH (BW)
      ) u_entry (
         .clk   (clk),
         .reset (reset),
         .flush (1'b0),
         .en    (wr_en[i]),
         .d     (bus.block_in),
         .q     (entries[i])
      );
   end

   // Read mux: the oldest entry, forced to zero while nothing is queued
   always_comb begin
      rd_data = entries[rd_ptr];
      if (empty) begin
         rd_data = '0;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.push_ready  = ~full;
   assign bus.pop_valid   = ~empty;
   assign bus.block_out   = rd_data;
   assign bus.count       = count_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = (count_q >= AFULL_CNT);

endmodule

// File: tb/tb_instruction_fetch_fifo.sv
// Scoreboard bench for the instruction fetch queue. The driver keeps its own
// occupancy model and queues expected blocks as pushes are issued; a monitor
// compares block_out with the queue head whenever the queue hands a block over.
module tb_instruction_fetch_fifo;
   import ifq_pkg::*;

   localparam int DW    = 32;
   localparam int IPB   = 4;
   localparam int DEPTH = 4;
   localparam int BW    = DW * IPB;

   logic clk;
   logic reset;

   int total = 0;
   int bad   = 0;
   int model_count = 0;
   int max_count   = 0;

   logic [BW-1:0] exp_q [$];

   instruction_fetch_fifo_if #(
      .DATA_WIDTH      (DW),
      .INSNS_PER_BLOCK (IPB),
      .DEPTH           (DEPTH)
   ) bus ();

   instruction_fetch_fifo #(
      .DATA_WIDTH      (DW),
      .INSNS_PER_BLOCK (IPB),
      .DEPTH           (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [BW-1:0] blk(input logic [3:0] n);
      logic [BW-1:0] v;
      v = {(BW/4){n}};
      return v;
   endfunction

   function automatic logic [BW-1:0] seq_blk(input int i);
      logic [DW-1:0] w;
      w = 32'h0000_5A00 + 32'(i);
      return {IPB{w}};
   endfunction

   task automatic check_output(input string name, input logic [BW-1:0] actual,
                               input logic [BW-1:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Compare every status output and the head of the queue against the model
   task automatic check_state();
      check_output("count", BW'(bus.count), BW'(model_count));
      check_output("full", BW'(bus.full), BW'(model_count == DEPTH));
      check_output("empty", BW'(bus.empty), BW'(model_count == 0));
      check_output("almost_full", BW'(bus.almost_full), BW'(model_count >= DEPTH - 1));
      check_output("push_ready", BW'(bus.push_ready), BW'(model_count != DEPTH));
      check_output("pop_valid", BW'(bus.pop_valid), BW'(model_count != 0));
      if (model_count > 0) begin
         check_output("block_out_head", bus.block_out, exp_q[0]);
      end else begin
         check_output("block_out_zero", bus.block_out, '0);
      end
   endtask

   // Drive one cycle of handshakes, predict its effect, then check after the edge
   task automatic apply_stimulus(input logic pv, input logic [BW-1:0] d,
                                 input logic pr, input logic fl);
      logic take;
      logic give;
      take = pv && !fl && (model_count < DEPTH);
      give = pr && !fl && (model_count > 0);
      bus.push_valid = pv;
      bus.block_in   = d;
      bus.pop_ready  = pr;
      bus.flush      = fl;
      if (take) begin
         exp_q.push_back(d);
      end
      @(posedge clk);
      #1;
      bus.push_valid = 1'b0;
      bus.pop_ready  = 1'b0;
      bus.flush      = 1'b0;
      if (fl) begin
         exp_q.delete();
         model_count = 0;
      end else begin
         model_count = model_count + int'(take) - int'(give);
      end
      if (model_count > max_count) begin
         max_count = model_count;
      end
      check_state();
   endtask

   task automatic drain();
      while (model_count > 0) begin
         apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   // Monitor: whenever a block leaves the queue it must match the oldest expected block
   always @(negedge clk) begin
      if (reset && !bus.flush && bus.pop_valid && bus.pop_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pop: got %h expected no block", bus.block_out);
         end else begin
            check_output("pop_data", bus.block_out, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      reset          = 1'b0;
      bus.flush      = 1'b0;
      bus.push_valid = 1'b0;
      bus.pop_ready  = 1'b0;
      bus.block_in   = '0;

      #2;
      $display("[TB] reset state");
      check_state();
      #10 reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] fill to full, then drain in order");
      apply_stimulus(1'b1, blk(4'hA), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hB), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hC), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hD), 1'b0, 1'b0);
      check_output("full_after_four", BW'(bus.full), BW'(1));
      drain();

      $display("[TB] push while full is held off until a slot frees");
      apply_stimulus(1'b1, blk(4'hA), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hB), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hC), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hD), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hE), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'hE), 1'b1, 1'b0);
      apply_stimulus(1'b1, blk(4'hE), 1'b0, 1'b0);
      drain();

      $display("[TB] simultaneous push and pop at count 2, then hold");
      apply_stimulus(1'b1, blk(4'h1), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h2), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h3), 1'b1, 1'b0);
      check_output("count_after_pushpop", BW'(bus.count), BW'(2));
      check_output("head_after_pushpop", bus.block_out, blk(4'h2));
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("head_held", bus.block_out, blk(4'h2));
      drain();

      $display("[TB] interleaved traffic across pointer wrap");
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, seq_blk(i), (i % 3) != 0, 1'b0);
      end
      drain();
      check_output("max_count", BW'(max_count <= DEPTH), BW'(1));

      $display("[TB] flush overrides push and pop");
      apply_stimulus(1'b1, blk(4'h5), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h6), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h7), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h8), 1'b1, 1'b1);
      check_output("flush_empty", BW'(bus.empty), BW'(1));
      apply_stimulus(1'b1, blk(4'h9), 1'b0, 1'b0);
      drain();

      $display("[TB] asynchronous reset mid-cycle");
      apply_stimulus(1'b1, blk(4'h4), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h5), 1'b0, 1'b0);
      apply_stimulus(1'b1, blk(4'h6), 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_output("rst_empty", BW'(bus.empty), BW'(1));
      check_output("rst_count", BW'(bus.count), '0);
      check_output("rst_block_out", bus.block_out, '0);
      exp_q.delete();
      model_count = 0;
      reset = 1'b1;
      apply_stimulus(1'b1, blk(4'hF), 1'b0, 1'b0);
      check_output("push_after_reset", BW'(bus.count), BW'(1));
      drain();

      check_output("scoreboard_drained", BW'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
